// File: rtl/instr_loader.sv
// Program loader: receives a length-prefixed big-endian byte stream and
// writes it as 32-bit words into instruction memory. The core is held in
// reset for the whole load.
module instr_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  output logic                  instrWrite_out,
  output logic [ADDR_WIDTH-1:0] instr_address_out,
  output logic [31:0]           instr_out,
  output logic                  core_hold_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             count_q, count_d;       // words to load
  logic [15:0]             index_q, index_d;       // word being assembled
  logic [1:0]              byte_idx_q, byte_idx_d; // byte within the word
  logic [23:0]             word_q, word_d;         // first three bytes of a word
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             instr_q, instr_d;

  logic                    accept;
  logic [17:0]             byte_offset;

  // Handshake and status come straight from the state register, so an
  // asynchronous reset clears them in the same instant it clears the state.
  assign byte_ready_out    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                             (state_q == S_DATA);
  assign instrWrite_out    = (state_q == S_WRITE);
  assign busy_out          = (state_q != S_IDLE);
  assign core_hold_out     = (state_q != S_IDLE);
  assign done_out          = (state_q == S_DONE);
  assign instr_address_out = addr_q;
  assign instr_out         = instr_q;

  assign accept      = byte_valid_in && byte_ready_out;
  assign byte_offset = {index_q, 2'b00};

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every target a
    // default first, so no path leaves a variable unassigned (no latches).
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    instr_d    = instr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d    = S_LEN_HI;
          count_d    = '0;
          index_d    = '0;
          byte_idx_d = '0;
          word_d     = '0;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          count_d[15:8] = byte_in;
          state_d       = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          count_d[7:0] = byte_in;
          index_d      = '0;
          byte_idx_d   = '0;
          state_d      = ({count_q[15:8], byte_in} == 16'd0) ? S_DONE : S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word: latch it with its address.
            instr_d    = {word_q, byte_in};
            addr_d     = BASE_ADDR + ADDR_WIDTH'(byte_offset);
            word_d     = '0;
            byte_idx_d = '0;
            state_d    = S_WRITE;
          end else begin
            word_d     = {word_q[15:0], byte_in};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        // Compare in 17 bits so a full 65535-word load never wraps.
        index_d = index_q + 16'd1;
        state_d = (({1'b0, index_q} + 17'd1) < {1'b0, count_q}) ? S_DATA : S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset_in.
  always_ff @(posedge clock_in or negedge reset_in) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples the values from before the edge.
    if (!reset_in) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      index_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a scripted driver derives the required output of
// every cycle from the byte stream it sends, and one compare process checks
// all outputs against those requirements on each falling clock edge.
module tb_instr_loader;

  localparam int          AW      = 32;
  localparam logic [31:0] TB_BASE = 32'h0000_0000;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          start_in;
  logic [7:0]    byte_in;
  logic          byte_valid_in;
  logic          byte_ready_out;
  logic          instrWrite_out;
  logic [AW-1:0] instr_address_out;
  logic [31:0]   instr_out;
  logic          core_hold_out;
  logic          busy_out;
  logic          done_out;

  always #5 clock_in = ~clock_in;

  instr_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (TB_BASE)
  ) dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .start_in          (start_in),
    .byte_in           (byte_in),
    .byte_valid_in     (byte_valid_in),
    .byte_ready_out    (byte_ready_out),
    .instrWrite_out    (instrWrite_out),
    .instr_address_out (instr_address_out),
    .instr_out         (instr_out),
    .core_hold_out     (core_hold_out),
    .busy_out          (busy_out),
    .done_out          (done_out)
  );

  // Required output values for the current cycle.
  logic        exp_ready, exp_write, exp_busy, exp_done;
  logic [31:0] exp_addr, exp_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations used to pin the model with literal expectations.
  int          cyc       = 0;
  int          n_writes  = 0;
  int          done_cyc  = -1;
  int          start_cyc = 0;
  logic [31:0] last_wr_addr, last_wr_data;

  logic [31:0] prog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock_in) begin
    cyc++;
    check("byte_ready_out",    32'(byte_ready_out),    32'(exp_ready));
    check("instrWrite_out",    32'(instrWrite_out),    32'(exp_write));
    check("instr_address_out", instr_address_out,      exp_addr);
    check("instr_out",         instr_out,              exp_data);
    check("busy_out",          32'(busy_out),          32'(exp_busy));
    check("core_hold_out",     32'(core_hold_out),     32'(exp_busy));
    check("done_out",          32'(done_out),          32'(exp_done));
    if (instrWrite_out === 1'b1) begin
      n_writes++;
      last_wr_addr = instr_address_out;
      last_wr_data = instr_out;
    end
    if (done_out === 1'b1) done_cyc = cyc;
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // DONE cycle followed by one idle cycle; stray bytes must be ignored.
  task automatic finish_done();
    exp_ready     = 1'b0;
    exp_done      = 1'b1;
    byte_valid_in = 1'b1;
    byte_in       = 8'h5A;
    step();
    exp_done      = 1'b0;
    exp_busy      = 1'b0;
    step();
    byte_valid_in = 1'b0;
  endtask

  // Send the words in prog as a complete load. valid_pct sets how often
  // byte_valid_in is high; glitch holds start_in high in every DATA cycle.
  task automatic run_load(input int valid_pct, input bit glitch);
    logic [7:0]  bs[$];
    logic [15:0] c16;
    int          count;
    count = prog.size();
    c16   = 16'(count);
    bs.push_back(c16[15:8]);
    bs.push_back(c16[7:0]);
    foreach (prog[i]) begin
      bs.push_back(prog[i][31:24]);
      bs.push_back(prog[i][23:16]);
      bs.push_back(prog[i][15:8]);
      bs.push_back(prog[i][7:0]);
    end

    start_in      = 1'b1;
    byte_valid_in = 1'b0;
    step();
    start_cyc = cyc;
    start_in  = 1'b0;
    exp_busy  = 1'b1;
    exp_ready = 1'b1;

    for (int k = 0; k < bs.size(); k++) begin
      int tries;
      bit acc;
      tries = 0;
      acc   = 1'b0;
      while (!acc) begin
        bit v;
        v = (tries > 20) || ($urandom_range(99) < valid_pct);
        byte_valid_in = v;
        byte_in       = v ? bs[k] : 8'($urandom);
        start_in      = glitch && (k >= 2);
        step();
        start_in = 1'b0;
        acc      = v;
        tries++;
      end

      if (k == 1 && count == 0) begin
        finish_done();
      end else if (k >= 2 && ((k - 2) % 4) == 3) begin
        int w;
        w         = (k - 2) / 4;
        exp_ready = 1'b0;
        exp_write = 1'b1;
        exp_addr  = TB_BASE + 32'(4 * w);
        exp_data  = prog[w];
        // Offer the next byte while not ready: it must stay unconsumed.
        byte_valid_in = 1'b1;
        byte_in       = (k + 1 < bs.size()) ? bs[k + 1] : 8'hA5;
        step();
        exp_write = 1'b0;
        if (w + 1 < count) exp_ready = 1'b1;
        else               finish_done();
      end
    end
    byte_valid_in = 1'b0;
  endtask

  int wr0;

  initial begin
    reset_in      = 1'b0;
    start_in      = 1'b0;
    byte_in       = 8'h00;
    byte_valid_in = 1'b0;
    exp_ready = 1'b0; exp_write = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    exp_addr  = 32'h0; exp_data = 32'h0;
    step();
    step();
    reset_in = 1'b1;
    step();

    // Single word load.
    wr0  = n_writes;
    prog = '{32'h2008_0005};
    run_load(100, 1'b0);
    check("s1_write_count", 32'(n_writes - wr0), 32'd1);
    check("s1_write_addr",  last_wr_addr, 32'h0000_0000);
    check("s1_write_data",  last_wr_data, 32'h2008_0005);
    check("s1_core_hold",   32'(core_hold_out), 32'd0);

    // Two word load.
    wr0  = n_writes;
    prog = '{32'h1122_3344, 32'hDEAD_BEEF};
    run_load(100, 1'b0);
    check("s2_write_count", 32'(n_writes - wr0), 32'd2);
    check("s2_last_addr",   last_wr_addr, 32'h0000_0004);
    check("s2_last_data",   last_wr_data, 32'hDEAD_BEEF);

    // Empty load.
    wr0      = n_writes;
    done_cyc = -1;
    prog     = '{};
    run_load(100, 1'b0);
    check("s3_write_count", 32'(n_writes - wr0), 32'd0);
    check("s3_done_delay",  32'(done_cyc - start_cyc), 32'd3);

    // Three words back to back, then with a randomly toggling valid.
    prog = '{32'hCAFE_0001, 32'h0BAD_F00D, 32'h8000_0007};
    run_load(100, 1'b0);
    wr0 = n_writes;
    run_load(40, 1'b0);
    check("s4_write_count", 32'(n_writes - wr0), 32'd3);
    check("s4_last_addr",   last_wr_addr, 32'h0000_0008);

    // Reset after two data bytes aborts the load.
    wr0           = n_writes;
    start_in      = 1'b1;
    step();
    start_in      = 1'b0;
    exp_busy      = 1'b1;
    exp_ready     = 1'b1;
    byte_valid_in = 1'b1;
    foreach (prog[i]) begin end
    byte_in = 8'h00; step();
    byte_in = 8'h03; step();
    byte_in = 8'h12; step();
    byte_in = 8'h34; step();
    reset_in  = 1'b0;
    exp_ready = 1'b0; exp_busy = 1'b0; exp_write = 1'b0; exp_done = 1'b0;
    exp_addr  = 32'h0; exp_data = 32'h0;
    #1;
    check("rst_byte_ready", 32'(byte_ready_out), 32'd0);
    check("rst_busy",       32'(busy_out),       32'd0);
    check("rst_core_hold",  32'(core_hold_out),  32'd0);
    check("rst_address",    instr_address_out,   32'h0);
    check("rst_instr",      instr_out,           32'h0);
    byte_in = 8'h56;
    step();
    step();
    reset_in      = 1'b1;
    step();
    byte_valid_in = 1'b0;
    step();
    check("rst_no_write", 32'(n_writes - wr0), 32'd0);
    prog = '{32'h0102_0304, 32'hA0B0_C0D0};
    run_load(100, 1'b0);
    check("rst_reload_count", 32'(n_writes - wr0), 32'd2);
    check("rst_reload_last",  last_wr_addr, 32'h0000_0004);

    // start_in held high throughout DATA is ignored.
    wr0  = n_writes;
    prog = '{32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_FFFF};
    run_load(100, 1'b1);
    check("glitch_write_count", 32'(n_writes - wr0), 32'd3);

    // Random loads.
    for (int n = 0; n < 6; n++) begin
      int words;
      words = $urandom_range(6, 1);
      prog  = '{};
      for (int i = 0; i < words; i++) prog.push_back($urandom);
      run_load($urandom_range(100, 30), n[0]);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of the instruction write address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, byte address of the first loaded word.
REQ-003 clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-low reset.
REQ-005 start_in  input  1  one-cycle request to begin a load.
REQ-006 byte_in  input  8  program stream byte.
REQ-007 byte_valid_in  input  1  byte_in is valid.
REQ-008 byte_ready_out  output  1  loader accepts byte_in this cycle.
REQ-009 instrWrite_out  output  1  instruction memory write strobe.
REQ-010 instr_address_out  output  ADDR_WIDTH  instruction memory byte address.
REQ-011 instr_out  output  32  instruction word to write.
REQ-012 core_hold_out  output  1  core must be held in reset while high.
REQ-013 busy_out  output  1  load in progress.
REQ-014 done_out  output  1  one-cycle pulse when a load completes.

Function
REQ-015 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE.
REQ-016 SHALL accept a byte only on a rising edge where byte_valid_in and byte_ready_out are both 1.
REQ-017 byte_ready_out SHALL be 1 only in LEN_HI, LEN_LO and DATA.
REQ-018 IDLE: start_in=1 -> LEN_HI next cycle; busy_out and core_hold_out go 1 that same edge.
REQ-019 start_in SHALL be ignored in every state other than IDLE.
REQ-020 LEN_HI: accepted byte -> count[15:8], go to LEN_LO.
REQ-021 LEN_LO: accepted byte -> count[7:0].
- count=0: go to DONE.
- Otherwise: go to DATA with word index 0 and byte index 0.
REQ-022 DATA: words are assembled big-endian; the first accepted byte of a word -> bits [31:24], the last -> bits [7:0].
REQ-023 After the 4th byte of a word is accepted, the state SHALL be WRITE for exactly one cycle.
- instrWrite_out=1.
- instr_out = the assembled word.
- instr_address_out = BASE_ADDR + 4*index, computed modulo 2^ADDR_WIDTH.
REQ-024 WRITE -> DATA if index+1 < count, else DONE; index increments on leaving WRITE.
REQ-025 instrWrite_out SHALL be 0 in every state except WRITE.
REQ-026 instr_address_out and instr_out SHALL hold their last values outside WRITE.
REQ-027 DONE SHALL last one cycle.
- done_out=1.
- busy_out=0 and core_hold_out=0 from the next edge.
- Then return to IDLE.
REQ-028 No valid bytes arriving SHALL stall the loader indefinitely in its current state; there is no timeout.
REQ-029 Bytes offered while byte_ready_out=0 SHALL NOT be consumed or dropped.
REQ-030 The maximum load is 65535 words; the 16-bit word index SHALL NOT wrap within a load.

Reset
REQ-031 reset_in=0 SHALL immediately force state IDLE and set to 0:
- byte_ready_out, instrWrite_out, busy_out, done_out, core_hold_out;
- instr_address_out, instr_out, count, index, and the partial word.
REQ-032 Reset asserted mid-load SHALL abort the load.
- No further write strobes occur.
- The partial word is discarded.
- After reset release the loader waits in IDLE for start_in.

Verification
REQ-033 Bench SHALL cover these scenarios:
- Start; stream 00 01 20 08 00 05 -> one write, address 0x00000000, data 0x20080005; done_out pulses; core_hold_out falls.
- Start; stream 00 02 then 8 bytes -> writes at 0x0 and 0x4, each a single-cycle strobe; byte_ready_out=0 during each WRITE cycle.
- Start; stream 00 00 -> no write; done_out pulses 3 cycles after start.
- byte_valid_in toggled randomly in a 3-word load -> same three words and addresses as the back-to-back case.
- reset_in low after 2 data bytes -> all outputs 0 at once; a new load then writes address 0 again.
- start_in pulsed during DATA -> ignored; load completes normally.
